// File: rtl/dma_memory_map_mc_if.sv
// MMIO register port: single-cycle writes, reads returning data one cycle after rd_en.
interface mmio_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 64
) ();
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;

   modport user   (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
   modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
endinterface

// File: rtl/dma_memory_map_mc.sv
// Multi-channel DMA control register file: per-channel address/size registers,
// a GO/BUSY/DONE sequencer with sticky done and error flags, and a global summary word.
module dma_memory_map_mc #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned SIZE_WIDTH = 32,
   parameter int unsigned NUM_CH     = 4,
   parameter logic [15:0] BASE_ADDR  = 16'h0050
) (
   input  logic                                  clk,
   input  logic                                  rst,
   mmio_if.user                                  mmio,
   output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     rd_addr,
   output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     wr_addr,
   output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]     size,
   output logic [NUM_CH-1:0]                     go,
   input  logic [NUM_CH-1:0]                     done
);
   localparam logic [3:0] OFF_GO  = 4'h0;
   localparam logic [3:0] OFF_RDA = 4'h2;
   localparam logic [3:0] OFF_WRA = 4'h4;
   localparam logic [3:0] OFF_SZ  = 4'h6;
   localparam logic [3:0] OFF_ST  = 4'h8;
   localparam logic [3:0] OFF_CLR = 4'hA;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} ch_state_t;

   ch_state_t         state [NUM_CH];
   logic [NUM_CH-1:0] done_sticky;
   logic [NUM_CH-1:0] err;
   logic [NUM_CH-1:0] busy;

   logic [15:0]       woff;
   logic [15:0]       roff;
   logic [NUM_CH-1:0] whit;
   logic [NUM_CH-1:0] start;
   logic [NUM_CH-1:0] cfg_wr;
   logic [NUM_CH-1:0] err_set;
   logic [NUM_CH-1:0] err_clr;
   logic [NUM_CH-1:0] sticky_clr;
   logic [NUM_CH-1:0] fin;
   logic [63:0]       rd_mux;

   // Write decode and per-channel event qualification
   always_comb begin
      woff       = mmio.wr_addr - BASE_ADDR;
      whit       = '0;
      start      = '0;
      cfg_wr     = '0;
      err_set    = '0;
      err_clr    = '0;
      sticky_clr = '0;
      fin        = '0;
      busy       = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         busy[c]  = (state[c] == S_BUSY);
         whit[c]  = mmio.wr_en && (mmio.wr_addr >= BASE_ADDR) && (woff[15:4] == 12'(c));
         fin[c]   = busy[c] && done[c];
         cfg_wr[c] = whit[c] && !busy[c];
         start[c] = cfg_wr[c] && (woff[3:0] == OFF_GO) && mmio.wr_data[0] && (size[c] != '0);
         // A config write while busy, or a start with no work, flags an error
         err_set[c] = (whit[c] && busy[c] &&
                       (woff[3:0] == OFF_GO || woff[3:0] == OFF_RDA ||
                        woff[3:0] == OFF_WRA || woff[3:0] == OFF_SZ)) ||
                      (cfg_wr[c] && (woff[3:0] == OFF_GO) && mmio.wr_data[0] && (size[c] == '0));
         err_clr[c]    = whit[c] && (woff[3:0] == OFF_CLR) && mmio.wr_data[2];
         sticky_clr[c] = whit[c] && (woff[3:0] == OFF_CLR) && mmio.wr_data[0];
      end
   end

   // Read decode; unmapped and write-only locations return zero
   always_comb begin
      roff   = mmio.rd_addr - BASE_ADDR;
      rd_mux = '0;
      if (mmio.rd_addr >= BASE_ADDR) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (roff[15:4] == 12'(c)) begin
               case (roff[3:0])
                  OFF_RDA: rd_mux = 64'(rd_addr[c]);
                  OFF_WRA: rd_mux = 64'(wr_addr[c]);
                  OFF_SZ:  rd_mux = 64'(size[c]);
                  OFF_ST:  rd_mux = {61'd0, err[c], busy[c], done_sticky[c]};
                  default: rd_mux = '0;
               endcase
            end
         end
         if (roff == 16'(16 * NUM_CH)) rd_mux = 64'({busy, done_sticky});
      end
   end

   // Channel sequencers, config registers and registered read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) state[c] <= S_IDLE;
         go           <= '0;
         rd_addr      <= '0;
         wr_addr      <= '0;
         size         <= '0;
         done_sticky  <= '0;
         err          <= '0;
         mmio.rd_data <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            go[c] <= start[c];
            if (cfg_wr[c] && woff[3:0] == OFF_RDA) rd_addr[c] <= ADDR_WIDTH'(mmio.wr_data);
            if (cfg_wr[c] && woff[3:0] == OFF_WRA) wr_addr[c] <= ADDR_WIDTH'(mmio.wr_data);
            if (cfg_wr[c] && woff[3:0] == OFF_SZ)  size[c]    <= SIZE_WIDTH'(mmio.wr_data);

            // Setting events take priority over same-cycle clears
            if (err_set[c])      err[c] <= 1'b1;
            else if (err_clr[c]) err[c] <= 1'b0;

            if (fin[c])                          done_sticky[c] <= 1'b1;
            else if (start[c] || sticky_clr[c])  done_sticky[c] <= 1'b0;

            case (state[c])
               S_IDLE:  if (start[c]) state[c] <= S_BUSY;
               S_BUSY:  if (fin[c])   state[c] <= S_DONE;
               S_DONE: begin
                  if (start[c])           state[c] <= S_BUSY;
                  else if (sticky_clr[c]) state[c] <= S_IDLE;
               end
               default: state[c] <= S_IDLE;
            endcase
         end
         if (mmio.rd_en) mmio.rd_data <= rd_mux;
      end
   end
endmodule

// File: tb/tb_dma_memory_map_mc.sv
// Scoreboard bench for dma_memory_map_mc: read expectations are queued when the
// read is issued and compared when the registered read data appears.
module tb_dma_memory_map_mc;
   localparam int unsigned AW = 64;
   localparam int unsigned SW = 32;
   localparam int unsigned NC = 4;

   typedef struct {
      logic [15:0] a;
      logic [63:0] d;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NC-1:0][AW-1:0]      rd_addr;
   logic [NC-1:0][AW-1:0]      wr_addr;
   logic [NC-1:0][SW-1:0]      size;
   logic [NC-1:0]              go;
   logic [NC-1:0]              done;

   exp_t sbq[$];
   exp_t e;
   logic rd_cap = 1'b0;
   int   total = 0;
   int   bad = 0;

   mmio_if mmio ();

   dma_memory_map_mc dut (
      .clk     (clk),
      .rst     (rst),
      .mmio    (mmio),
      .rd_addr (rd_addr),
      .wr_addr (wr_addr),
      .size    (size),
      .go      (go),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_cap <= mmio.rd_en;

   // Pop and compare one expectation for every read the DUT has answered
   always @(negedge clk) begin
      if (rd_cap) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected: got %h with no expected entry", mmio.rd_data);
         end else begin
            e = sbq.pop_front();
            if (mmio.rd_data !== e.d) begin
               bad++;
               $display("FAIL rd_%h: got %h expected %h", e.a, mmio.rd_data, e.d);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      mmio.wr_en   = 1'b1;
      mmio.wr_addr = a;
      mmio.wr_data = d;
      tick();
      mmio.wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [63:0] d);
      sbq.push_back('{a: a, d: d});
      mmio.rd_en   = 1'b1;
      mmio.rd_addr = a;
      tick();
      mmio.rd_en   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mmio.wr_en = 1'b0; mmio.wr_addr = '0; mmio.wr_data = '0;
      mmio.rd_en = 1'b0; mmio.rd_addr = '0;
      done = '0;
      repeat (3) tick();
      total++;
      if (go !== '0 || rd_addr !== '0 || wr_addr !== '0 || size !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got go=%b size=%h expected all zero", go, size);
      end
      total++;
      if (mmio.rd_data !== 64'h0) begin
         bad++;
         $display("FAIL reset_rd_data: got %h expected 0", mmio.rd_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ch0_transfer();
      wr(16'h52, 64'h1000);
      wr(16'h54, 64'h2000);
      wr(16'h56, 64'h4);
      wr(16'h50, 64'h1);
      total++;
      if (go !== 4'b0001) begin
         bad++;
         $display("FAIL go0_pulse: got %b expected 0001", go);
      end
      tick();
      total++;
      if (go !== 4'b0000) begin
         bad++;
         $display("FAIL go0_single: got %b expected 0000", go);
      end
      total++;
      if (rd_addr[0] !== 64'h1000 || wr_addr[0] !== 64'h2000 || rd_addr[1] !== 64'h0) begin
         bad++;
         $display("FAIL ch0_addr: got rd=%h wr=%h rd1=%h expected 1000 2000 0",
                  rd_addr[0], wr_addr[0], rd_addr[1]);
      end
      rd(16'h58, 64'h2);
      wr(16'h56, 64'h9);
      total++;
      if (size[0] !== 32'h4) begin
         bad++;
         $display("FAIL busy_size_hold: got %h expected 4", size[0]);
      end
      rd(16'h58, 64'h6);
      done[0] = 1'b1;
      tick();
      done[0] = 1'b0;
      rd(16'h58, 64'h5);
      rd(16'h90, 64'h1);
      rd(16'h52, 64'h1000);
   endtask

   task automatic test_size_zero();
      wr(16'h60, 64'h1);
      total++;
      if (go !== 4'b0000) begin
         bad++;
         $display("FAIL go1_size0: got %b expected 0000", go);
      end
      rd(16'h68, 64'h4);
      wr(16'h6A, 64'h4);
      rd(16'h68, 64'h0);
   endtask

   task automatic test_clear_race();
      wr(16'h76, 64'h1);
      wr(16'h70, 64'h1);
      total++;
      if (go !== 4'b0100) begin
         bad++;
         $display("FAIL go2_first: got %b expected 0100", go);
      end
      mmio.wr_en = 1'b1; mmio.wr_addr = 16'h7A; mmio.wr_data = 64'h1;
      done[2] = 1'b1;
      tick();
      mmio.wr_en = 1'b0;
      done[2] = 1'b0;
      rd(16'h78, 64'h1);
      wr(16'h70, 64'h1);
      total++;
      if (go !== 4'b0100) begin
         bad++;
         $display("FAIL go2_restart: got %b expected 0100", go);
      end
      rd(16'h78, 64'h2);
      rd(16'h90, 64'h41);
   endtask

   task automatic test_reserved();
      rd(16'h5C, 64'h0);
      rd(16'h92, 64'h0);
      rd(16'h50, 64'h0);
      rd(16'h4E, 64'h0);
      rd(16'h5E, 64'h0);
   endtask

   task automatic test_rst_mid();
      logic [NC-1:0] go_seen;
      wr(16'h86, 64'h2);
      wr(16'h80, 64'h1);
      tick();
      rd(16'h54, 64'h2000);
      tick();
      rst = 1'b1;
      done[3] = 1'b1;
      #2;
      total++;
      if (go !== '0 || rd_addr !== '0 || wr_addr !== '0 || size !== '0 || mmio.rd_data !== 64'h0) begin
         bad++;
         $display("FAIL async_rst: got go=%b size=%h rd_data=%h expected zeros", go, size, mmio.rd_data);
      end
      tick();
      rst = 1'b0;
      done[3] = 1'b0;
      go_seen = '0;
      for (int i = 0; i < 3; i++) begin
         go_seen = go_seen | go;
         tick();
      end
      total++;
      if (go_seen !== '0) begin
         bad++;
         $display("FAIL rst_no_go: got %b expected 0000", go_seen);
      end
      rd(16'h88, 64'h0);
      rd(16'h90, 64'h0);
   endtask

   task automatic test_back_to_back();
      wr(16'h52, 64'hAAAA);
      sbq.push_back('{a: 16'h52, d: 64'hAAAA});
      mmio.rd_en = 1'b1; mmio.rd_addr = 16'h52;
      mmio.wr_en = 1'b1; mmio.wr_addr = 16'h52; mmio.wr_data = 64'h5555;
      tick();
      mmio.rd_en = 1'b0;
      mmio.wr_en = 1'b0;
      wr(16'h54, 64'h1234_5678_9ABC_DEF0);
      wr(16'h56, 64'hFFFF_FFFF_1234_5678);
      total++;
      if (size[0] !== 32'h1234_5678) begin
         bad++;
         $display("FAIL size_trunc: got %h expected 12345678", size[0]);
      end
      rd(16'h52, 64'h5555);
      rd(16'h54, 64'h1234_5678_9ABC_DEF0);
      rd(16'h5C, 64'h0);
      rd(16'h56, 64'h1234_5678);
      repeat (3) tick();
      total++;
      if (mmio.rd_data !== 64'h1234_5678) begin
         bad++;
         $display("FAIL rd_hold: got %h expected 12345678", mmio.rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_ch0_transfer();
      test_size_zero();
      test_clear_race();
      test_reserved();
      test_rst_mid();
      test_back_to_back();
      for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
